// File: rtl/adc_sample_fifo.sv
// adc_sample_fifo: samples the ADC bus at a programmable rate, tags each sample with a 4-bit sequence number and buffers it in a RAM FIFO
module adc_sample_fifo #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 9,
  parameter int DIV_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] adc_d,
  input  logic              enable,
  input  logic [DIV_W-1:0]  div,
  input  logic              clear,
  input  logic              rd_en,
  output logic [DATA_W+3:0] rd_data,
  output logic              rd_valid,
  output logic [ADDR_W:0]   level,
  output logic              empty,
  output logic              full,
  output logic              overflow
);
  logic [DATA_W-1:0] s1, s2;
  logic [DIV_W-1:0]  dcnt;
  logic [3:0]        seq;
  logic [ADDR_W:0]   wptr, rptr;
  logic [DATA_W+3:0] mem [2**ADDR_W];
  logic              flush, tick, wr, rd;
  assign flush = rst || clear;
  assign tick  = enable && dcnt == div;
  assign level = wptr - rptr;
  assign empty = level == '0;
  assign full  = level[ADDR_W];
  assign wr    = tick && !full && !flush;
  assign rd    = rd_en && !empty && !flush;
  always_ff @(posedge clk) begin
    s1 <= rst ? '0 : adc_d;
    s2 <= rst ? '0 : s1;
  end
  always_ff @(posedge clk) begin
    if (flush) begin
      dcnt     <= '0;
      seq      <= '0;
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      dcnt     <= (tick || !enable) ? '0 : dcnt + 1'b1;
      seq      <= tick ? seq + 1'b1 : seq;
      wptr     <= wr ? wptr + 1'b1 : wptr;
      rptr     <= rd ? rptr + 1'b1 : rptr;
      overflow <= overflow || (tick && full);
      rd_valid <= rd;
    end
  end
  always_ff @(posedge clk) begin
    if (wr) mem[wptr[ADDR_W-1:0]] <= {seq, s2};
  end
  always_ff @(posedge clk) begin
    if (rst) rd_data <= '0;
    else if (rd) rd_data <= mem[rptr[ADDR_W-1:0]];
  end
endmodule

// File: tb/tb_adc_sample_fifo.sv
// tb_adc_sample_fifo: randomized scoreboard bench against a queue-based reference model
module tb_adc_sample_fifo;
  logic        clk = 0, rst = 1, enable = 0, clear = 0, rd_en = 0;
  logic [11:0] adc_d = 12'hABC;
  logic [7:0]  div = 8'd3;
  logic [15:0] rd_data;
  logic        rd_valid, empty, full, overflow;
  logic [9:0]  level;

  adc_sample_fifo dut (
    .clk(clk), .rst(rst), .adc_d(adc_d), .enable(enable), .div(div), .clear(clear),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .level(level),
    .empty(empty), .full(full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  logic [15:0] mq[$], exp_q[$];
  logic [11:0] hist[$];
  int phase = 0, m_seq = 0;
  bit m_ovf = 0, m_vld = 0, mon_on = 0;
  logic [15:0] m_rd = '0;

  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endfunction

  // reference model: FIFO contents as a queue, sample period as a phase count
  always @(posedge clk) begin
    bit t, f, e;
    if (rst || clear) begin
      mq.delete();
      m_seq = 0;
      phase = 0;
      m_ovf = 0;
      m_vld = 0;
      if (rst) begin
        m_rd = '0;
        hist.delete();
        hist.push_back(12'h0);
        hist.push_back(12'h0);
      end
    end else begin
      t = enable && phase == int'(div);
      phase = (!enable || t) ? 0 : (phase + 1) % 256;
      f = mq.size() == 512;
      e = mq.size() == 0;
      m_vld = rd_en && !e;
      if (m_vld) begin
        m_rd = mq.pop_front();
        exp_q.push_back(m_rd);
      end
      if (t) begin
        if (f) m_ovf = 1;
        else mq.push_back({4'(m_seq), hist[hist.size()-2]});
        m_seq = (m_seq + 1) % 16;
      end
    end
    if (!rst) hist.push_back(adc_d);
    if (hist.size() > 3) void'(hist.pop_front());
    mon_on = 1;
  end

  always @(negedge clk) begin
    if (mon_on) begin
      chk("level", 32'(level), mq.size());
      chk("empty", 32'(empty), 32'(mq.size() == 0));
      chk("full", 32'(full), 32'(mq.size() == 512));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("rd_valid", 32'(rd_valid), 32'(m_vld));
      chk("rd_data_hold", 32'(rd_data), 32'(m_rd));
      if (rd_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pop_word: rd_valid with no expected word, got %0h", rd_data);
        end else begin
          logic [15:0] w;
          w = exp_q.pop_front();
          if (rd_data !== w) begin
            errors++;
            $display("FAIL pop_word: got %0h expected %0h", rd_data, w);
          end
        end
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    clear = 1;
    step(1);
    clear = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    step(2);
    rst = 0;
    @(negedge clk);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_overflow", 32'(overflow), 0);

    enable = 1;
    step(40);
    enable = 0;
    @(negedge clk);
    chk("div3_writes", 32'(level), 10);
    rd_en = 1;
    step(1);
    rd_en = 0;
    @(negedge clk);
    chk("first_pop", 32'(rd_data), 32'h0ABC);
    chk("first_pop_valid", 32'(rd_valid), 1);
    rd_en = 1;
    step(9);
    rd_en = 0;
    step(2);
    @(negedge clk);
    chk("div3_drained", 32'(empty), 1);

    pulse_clear();
    div = 0;
    enable = 1;
    for (int i = 0; i < 515; i++) begin
      adc_d = 12'($urandom);
      step(1);
    end
    enable = 0;
    @(negedge clk);
    chk("fill_full", 32'(full), 1);
    chk("fill_level", 32'(level), 512);
    chk("fill_overflow", 32'(overflow), 1);
    rd_en = 1;
    step(512);
    rd_en = 0;
    step(2);
    @(negedge clk);
    chk("drain_empty", 32'(empty), 1);
    chk("overflow_sticky", 32'(overflow), 1);

    enable = 1;
    rd_en = 1;
    step(1);
    enable = 0;
    rd_en = 0;
    @(negedge clk);
    chk("empty_rw_level", 32'(level), 1);
    chk("empty_rw_valid", 32'(rd_valid), 0);

    pulse_clear();
    enable = 1;
    step(512);
    enable = 0;
    @(negedge clk);
    chk("full_again", 32'(full), 1);
    chk("full_no_ovf", 32'(overflow), 0);
    enable = 1;
    rd_en = 1;
    step(1);
    enable = 0;
    rd_en = 0;
    @(negedge clk);
    chk("full_rw_level", 32'(level), 511);
    chk("full_rw_ovf", 32'(overflow), 1);
    chk("full_rw_valid", 32'(rd_valid), 1);

    pulse_clear();
    enable = 1;
    step(5);
    rd_en = 1;
    step(1);
    enable = 0;
    rd_en = 0;
    @(negedge clk);
    chk("mid_rw_level", 32'(level), 5);

    pulse_clear();
    enable = 1;
    step(100);
    @(negedge clk);
    chk("pre_clear_level", 32'(level), 100);
    clear = 1;
    rd_en = 1;
    step(1);
    clear = 0;
    rd_en = 0;
    @(negedge clk);
    chk("clear_level", 32'(level), 0);
    chk("clear_empty", 32'(empty), 1);
    chk("clear_ovf", 32'(overflow), 0);
    chk("clear_valid", 32'(rd_valid), 0);
    step(1);
    enable = 0;
    rd_en = 1;
    step(1);
    rd_en = 0;
    @(negedge clk);
    chk("post_clear_valid", 32'(rd_valid), 1);
    chk("post_clear_seq", 32'(rd_data[15:12]), 0);

    pulse_clear();
    div = 5;
    enable = 1;
    step(2);
    enable = 0;
    step(7);
    @(negedge clk);
    chk("gate_no_write", 32'(level), 0);
    enable = 1;
    step(5);
    @(negedge clk);
    chk("gate_before_tick", 32'(level), 0);
    step(1);
    @(negedge clk);
    chk("gate_first_tick", 32'(level), 1);

    for (int i = 0; i < 3000; i++) begin
      adc_d  = 12'($urandom);
      enable = ($urandom % 4) != 0;
      rd_en  = ($urandom % 100) < (i < 1500 ? 10 : 60);
      clear  = ($urandom % 300) == 0;
      if ($urandom % 50 == 0) div = 8'($urandom_range(0, 7));
      if ($urandom % 700 == 0) div = 8'd200;
      step(1);
    end
    enable = 0;
    rd_en  = 0;
    clear  = 0;
    step(3);
    @(negedge clk);
    chk("scoreboard_leftover", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
